// File: rtl/pc_sequencer.sv
// Program counter sequencer: fetch/execute phase FSM, instruction register,
// 4-deep return stack with sticky overflow/underflow and halt detection.
module pc_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  PS,
  input  logic        IL,
  input  logic        MP,
  input  logic [15:0] instr_in,
  output logic        state,
  output logic [7:0]  pc,
  output logic [15:0] ir,
  output logic [3:0]  opcode,
  output logic [3:0]  eoe,
  output logic        halted,
  output logic        stk_ovf,
  output logic        stk_unf
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } phase_e;

  phase_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  stk_q [4];
  logic [7:0]  stk_d [4];
  logic [2:0]  cnt_q, cnt_d;
  logic        halt_q, halt_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic [7:0]  pc_inc;
  logic [7:0]  pc_br;
  logic [1:0]  top_idx;
  logic        is_halt;

  // an 8-bit offset sign-extended to 8 bits is the raw byte mod 256
  assign pc_inc  = pc_q + 8'd1;
  assign pc_br   = pc_q + ir_q[7:0];
  assign top_idx = cnt_q[1:0] - 2'd1;
  assign is_halt = (ir_q[15:12] == 4'hF) && (ir_q[3:0] == 4'hF);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    stk_d   = stk_q;
    cnt_d   = cnt_q;
    halt_d  = halt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (!halt_q) begin
      unique case (state_q)
        FETCH: begin
          if (IL) ir_d = instr_in;
          state_d = EXEC;
        end
        EXEC: begin
          state_d = FETCH;
          if (MP) begin
            pc_d = pc_br;
            if (cnt_q == 3'd4) begin
              // full: drop the oldest entry at the bottom
              stk_d[0] = stk_q[1];
              stk_d[1] = stk_q[2];
              stk_d[2] = stk_q[3];
              stk_d[3] = pc_inc;
              ovf_d    = 1'b1;
            end else begin
              stk_d[cnt_q[1:0]] = pc_inc;
              cnt_d = cnt_q + 3'd1;
            end
          end else begin
            unique case (PS)
              2'b00: if (is_halt) halt_d = 1'b1;
              2'b01: pc_d = pc_inc;
              2'b10: pc_d = pc_br;
              2'b11: begin
                if (cnt_q != 3'd0) begin
                  pc_d  = stk_q[top_idx];
                  cnt_d = cnt_q - 3'd1;
                end else begin
                  pc_d  = pc_inc;
                  unf_d = 1'b1;
                end
              end
            endcase
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= 8'h00;
      ir_q    <= 16'h0000;
      cnt_q   <= 3'd0;
      halt_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < 4; i++) stk_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      for (int i = 0; i < 4; i++) stk_q[i] <= stk_d[i];
    end
  end

  assign state   = state_q;
  assign pc      = pc_q;
  assign ir      = ir_q;
  assign opcode  = ir_q[15:12];
  assign eoe     = ir_q[3:0];
  assign halted  = halt_q;
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random
// steps compared against a queue-based reference model.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic [1:0]  PS;
  logic        IL;
  logic        MP;
  logic [15:0] instr_in;
  logic        state;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  eoe;
  logic        halted;
  logic        stk_ovf;
  logic        stk_unf;

  int checks;
  int failures;

  int          m_phase;
  int          m_pc;
  logic [15:0] m_ir;
  int          m_stk[$];
  bit          m_halt;
  bit          m_ovf;
  bit          m_unf;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .PS(PS), .IL(IL), .MP(MP),
    .instr_in(instr_in), .state(state), .pc(pc), .ir(ir),
    .opcode(opcode), .eoe(eoe), .halted(halted),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("state", {15'd0, state}, 16'(m_phase));
    chk("pc", {8'd0, pc}, 16'(m_pc));
    chk("ir", ir, m_ir);
    chk("opcode", {12'd0, opcode}, {12'd0, m_ir[15:12]});
    chk("eoe", {12'd0, eoe}, {12'd0, m_ir[3:0]});
    chk("halted", {15'd0, halted}, {15'd0, m_halt});
    chk("stk_ovf", {15'd0, stk_ovf}, {15'd0, m_ovf});
    chk("stk_unf", {15'd0, stk_unf}, {15'd0, m_unf});
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pc    = 0;
    m_ir    = 16'h0000;
    m_stk.delete();
    m_halt  = 0;
    m_ovf   = 0;
    m_unf   = 0;
  endtask

  // One clock edge of architectural behaviour from the rules, not the RTL
  task automatic model_edge(input logic [1:0] ps, input bit il,
                            input bit mp, input logic [15:0] ins);
    int off;
    if (m_halt) return;
    if (m_phase == 0) begin
      if (il) m_ir = ins;
      m_phase = 1;
      return;
    end
    m_phase = 0;
    off = int'($signed(m_ir[7:0]));
    if (mp) begin
      if (m_stk.size() == 4) begin
        void'(m_stk.pop_front());
        m_ovf = 1;
      end
      m_stk.push_back((m_pc + 1) % 256);
      m_pc = (m_pc + off + 256) % 256;
    end else if (ps == 2'b01) begin
      m_pc = (m_pc + 1) % 256;
    end else if (ps == 2'b10) begin
      m_pc = (m_pc + off + 256) % 256;
    end else if (ps == 2'b11) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin
        m_pc  = (m_pc + 1) % 256;
        m_unf = 1;
      end
    end else if (m_ir[15:12] == 4'hF && m_ir[3:0] == 4'hF) begin
      m_halt = 1;
    end
  endtask

  task automatic step(input logic [1:0] ps, input bit il, input bit mp,
                      input logic [15:0] ins);
    PS = ps; IL = il; MP = mp; instr_in = ins;
    @(posedge clk);
    model_edge(ps, il, mp, ins);
    #1;
    check_all();
  endtask

  // fetch an instruction, then execute it with the given controls
  task automatic run(input logic [15:0] ins, input logic [1:0] ps,
                     input bit mp);
    step(2'b00, 1'b1, 1'b0, ins);
    step(ps, 1'b0, mp, 16'h0000);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    model_reset();
    check_all();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    PS       = 2'b00;
    IL       = 1'b0;
    MP       = 1'b0;
    instr_in = 16'h0000;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // load then increment
    step(2'b01, 1'b1, 1'b0, 16'h0123);
    chk("ld_ir", ir, 16'h0123);
    step(2'b01, 1'b0, 1'b0, 16'h0000);
    chk("inc_pc", {8'd0, pc}, 16'h0001);
    chk("toggle", {15'd0, state}, 16'h0000);

    // branch arithmetic and wrap
    run(16'h000F, 2'b10, 1'b0);
    run(16'h00FC, 2'b10, 1'b0);
    chk("br_back", {8'd0, pc}, 16'h000C);
    run(16'h00F3, 2'b10, 1'b0);
    chk("at_ff", {8'd0, pc}, 16'h00FF);
    run(16'h0000, 2'b01, 1'b0);
    chk("wrap", {8'd0, pc}, 16'h0000);

    // call then return
    run(16'h0020, 2'b10, 1'b0);
    run(16'h0010, 2'b00, 1'b1);
    chk("call", {8'd0, pc}, 16'h0030);
    run(16'h0000, 2'b11, 1'b0);
    chk("ret", {8'd0, pc}, 16'h0021);

    // five calls overflow, five returns underflow
    do_reset();
    run(16'h0000, 2'b01, 1'b0);
    for (int i = 0; i < 5; i++) begin
      run(16'h000F, 2'b01, 1'b1);
      if (i < 4) run(16'h0000, 2'b01, 1'b0);
    end
    chk("ovf", {15'd0, stk_ovf}, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      run(16'h0000, 2'b11, 1'b0);
      chk("ret_seq", {8'd0, pc}, 16'(8'h42 - 8'(i * 16)));
    end
    run(16'h0000, 2'b11, 1'b0);
    chk("unf", {15'd0, stk_unf}, 16'h0001);

    // halt freezes everything
    run(16'hF00F, 2'b00, 1'b0);
    chk("halt", {15'd0, halted}, 16'h0001);
    for (int i = 0; i < 10; i++)
      step(2'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
    do_reset();

    // async reset in EXEC aborts the branch
    run(16'h0040, 2'b10, 1'b0);
    step(2'b00, 1'b1, 1'b0, 16'h0040);
    PS = 2'b10;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b10, 1'b1, 1'b0, 16'h0005);
    step(2'b01, 1'b0, 1'b0, 16'h0000);
    chk("post_rst", {8'd0, pc}, 16'h0001);

    // random soak, halt encodings excluded
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      if (ins[15:12] == 4'hF && ins[3:0] == 4'hF) ins[0] = 1'b0;
      step(2'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), ins);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset; assertion takes effect immediately, release is sampled on clk.
REQ-003 PS  input  2  PC select from control logic: 00 hold, 01 increment, 10 branch by offset, 11 return (pop).
REQ-004 IL  input  1  instruction load enable from control logic.
REQ-005 MP  input  1  call enable from control logic: push return address and jump.
REQ-006 instr_in  input  16  instruction word read from instruction memory at address pc.
REQ-007 state  output  1  cycle phase driven to control logic: 0 fetch, 1 execute.
REQ-008 pc  output  8  current program counter, instruction memory address.
REQ-009 ir  output  16  instruction register.
REQ-010 opcode  output  4  ir[15:12], combinational from ir.
REQ-011 eoe  output  4  ir[3:0], combinational from ir.
REQ-012 halted  output  1  sticky halt indicator.
REQ-013 stk_ovf  output  1  sticky return-stack overflow flag.
REQ-014 stk_unf  output  1  sticky return-stack underflow flag.

Function
REQ-015 Phase FSM SHALL be two states, FETCH (state=0) and EXEC (state=1), alternating every clk while halted=0.
REQ-016 In FETCH with IL=1, ir SHALL load instr_in at the clock edge; IL=0 holds ir; pc SHALL not change in FETCH regardless of PS.
REQ-017 pc, ir, return stack and flags SHALL update only at the EXEC->FETCH edge (except ir per REQ-016).
REQ-018 Offset SHALL be ir[7:0] sign-extended to 8 bits; all pc arithmetic modulo 256 (255+1 -> 0; 2 + 0xFE -> 0).
REQ-019 EXEC, MP=0, PS=01: pc <= pc+1.
REQ-020 EXEC, MP=0, PS=10: pc <= pc + offset.
REQ-021 EXEC, MP=0, PS=11: if stack non-empty, pc <= top entry and pop; if empty, pc <= pc+1 and stk_unf <= 1.
REQ-022 EXEC, MP=0, PS=00: pc holds; if opcode=4'b1111 and eoe=4'b1111, halted <= 1.
REQ-023 EXEC, MP=1: push pc+1 and pc <= pc + offset, irrespective of PS.
REQ-024 Return stack: 4 entries x 8 bits, LIFO, occupancy count 0..4.
REQ-025 Push when full (count=4): discard oldest entry, store new entry on top, count stays 4, stk_ovf <= 1.
REQ-026 Push and pop are never simultaneous (MP has priority per REQ-023).
REQ-027 halted=1 SHALL freeze state at 0, pc, ir, stack and flags; only rst_n clears it.
REQ-028 stk_ovf, stk_unf remain 1 until reset.

Reset
REQ-029 rst_n=0 SHALL force state=0, pc=8'h00, ir=16'h0000, stack count=0, entries=0, halted=0, stk_ovf=0, stk_unf=0.
REQ-030 Reset asserted mid-EXEC SHALL abort the pending update; first cycle after release is FETCH at pc=0.

Verification
REQ-031 Reset, instr_in=16'h0123, IL=1 then PS=01 -> ir=16'h0123 after first edge, pc=1 after second edge, state toggles 0,1,0.
REQ-032 pc=8'h10, ir[7:0]=8'hFC, PS=10 in EXEC -> pc=8'h0C; pc=8'hFF, PS=01 -> pc=8'h00.
REQ-033 pc=8'h20, ir[7:0]=8'h10, MP=1 -> pc=8'h30, stack top=8'h21; then PS=11 in EXEC -> pc=8'h21, stack empty.
REQ-034 Five consecutive calls from pc 0x01,0x11,0x21,0x31,0x41 (offset 0x0F) -> stk_ovf=1; four returns yield 0x42,0x32,0x22,0x12; fifth return -> pc+1, stk_unf=1.
REQ-035 ir=16'hF00F, PS=00 in EXEC -> halted=1, pc and state frozen for 10 cycles; rst_n pulse low -> all outputs to REQ-029 values.
REQ-036 rst_n asserted asynchronously between edges during EXEC with PS=10 -> pc=0 immediately, no branch applied after release.
